// File: rtl/tdm_demux_1x16_if.sv
// Serial TDM input and demultiplexed frame output bundle for tdm_demux_1x16.
// The master drives the serial side; the slave is the demultiplexer.
interface tdm_demux_1x16_if;
  logic        din;
  logic        en;
  logic        sync;
  logic [15:0] dout;
  logic        frame_valid;
  logic        sync_err;
  logic        locked;
  logic [3:0]  slot;

  modport master (
    output din, en, sync,
    input  dout, frame_valid, sync_err, locked, slot
  );

  modport slave (
    input  din, en, sync,
    output dout, frame_valid, sync_err, locked, slot
  );
endinterface

// File: rtl/tdm_demux_1x16.sv
// 1-to-16 TDM demultiplexer: collects 16 serial slots framed by sync into a
// parallel word, with framing-error detection and an optional free-run mode.
module tdm_demux_1x16 #(
  parameter bit STRICT_SYNC = 1'b1
) (
  input logic              clk,
  input logic              rst,
  tdm_demux_1x16_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  slot_q, slot_n;
  logic [14:0] shift_q, shift_n;
  logic [15:0] dout_q, dout_n;
  logic        fv_q, fv_n;
  logic        se_q, se_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      slot_q  <= 4'd0;
      shift_q <= 15'd0;
      dout_q  <= 16'h0000;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state   <= state_n;
      slot_q  <= slot_n;
      shift_q <= shift_n;
      dout_q  <= dout_n;
      fv_q    <= fv_n;
      se_q    <= se_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = slot_q;
    shift_n = shift_q;
    dout_n  = dout_q;
    fv_n    = 1'b0;
    se_n    = 1'b0;
    if (bus.en) begin
      unique case (state)
        IDLE: begin
          if (bus.sync) begin
            shift_n[0] = bus.din;
            slot_n     = 4'd1;
            state_n    = RUN;
          end
        end
        RUN: begin
          // Early sync wins over everything, including a slot-15 completion.
          if (bus.sync && slot_q != 4'd0) begin
            se_n    = 1'b1;
            shift_n = {14'd0, bus.din};
            slot_n  = 4'd1;
          end else if (!bus.sync && slot_q == 4'd0 && STRICT_SYNC) begin
            se_n    = 1'b1;
            state_n = IDLE;
          end else if (slot_q == 4'd15) begin
            dout_n = {bus.din, shift_q};
            fv_n   = 1'b1;
            slot_n = 4'd0;
          end else begin
            for (int i = 0; i < 15; i++)
              if (slot_q == 4'(i)) shift_n[i] = bus.din;
            slot_n = slot_q + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = se_q;
  assign bus.locked      = (state == RUN);
  assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Bench for tdm_demux_1x16: strict and free-running instances share one
// stimulus stream and are compared against a frame-collecting reference.
module tb_tdm_demux_1x16;

  logic clk, rst;
  logic din, en, sync;

  tdm_demux_1x16_if bus_s ();
  tdm_demux_1x16_if bus_f ();

  assign bus_s.din = din;  assign bus_s.en = en;  assign bus_s.sync = sync;
  assign bus_f.din = din;  assign bus_f.en = en;  assign bus_f.sync = sync;

  tdm_demux_1x16 #(.STRICT_SYNC(1'b1)) u_strict (.clk(clk), .rst(rst), .bus(bus_s));
  tdm_demux_1x16 #(.STRICT_SYNC(1'b0)) u_free   (.clk(clk), .rst(rst), .bus(bus_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;

  // Reference: index 0 strict, index 1 free-running. A frame is the list of
  // bits collected since the last sync; its length is the next slot.
  bit          m_lock [2];
  int          m_len  [2];
  logic [15:0] m_frame[2];
  logic [15:0] m_dout [2];
  bit          m_fv   [2];
  bit          m_se   [2];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lock[m] = 0; m_len[m] = 0; m_frame[m] = '0;
      m_dout[m] = '0; m_fv[m] = 0; m_se[m] = 0;
    end
  endfunction

  function automatic void model_step(input logic d, input logic e, input logic s);
    for (int m = 0; m < 2; m++) begin
      m_fv[m] = 0;
      m_se[m] = 0;
      if (!e) continue;
      if (!m_lock[m]) begin
        if (s) begin
          m_lock[m] = 1; m_frame[m] = 16'(d); m_len[m] = 1;
        end
      end else if (s && m_len[m] != 0) begin
        m_se[m] = 1; m_frame[m] = 16'(d); m_len[m] = 1;
      end else if (!s && m_len[m] == 0 && m == 0) begin
        m_se[m] = 1; m_lock[m] = 0;
      end else begin
        m_frame[m][m_len[m]] = d;
        m_len[m]++;
        if (m_len[m] == 16) begin
          m_dout[m] = m_frame[m]; m_fv[m] = 1; m_len[m] = 0;
        end
      end
    end
  endfunction

  task automatic check_all();
    check("dout_strict",   bus_s.dout,               m_dout[0]);
    check("fv_strict",     16'(bus_s.frame_valid),   16'(m_fv[0]));
    check("serr_strict",   16'(bus_s.sync_err),      16'(m_se[0]));
    check("locked_strict", 16'(bus_s.locked),        16'(m_lock[0]));
    check("slot_strict",   16'(bus_s.slot),          16'(m_len[0]));
    check("dout_free",     bus_f.dout,               m_dout[1]);
    check("fv_free",       16'(bus_f.frame_valid),   16'(m_fv[1]));
    check("serr_free",     16'(bus_f.sync_err),      16'(m_se[1]));
    check("locked_free",   16'(bus_f.locked),        16'(m_lock[1]));
    check("slot_free",     16'(bus_f.slot),          16'(m_len[1]));
  endtask

  // Called at a negedge: drive, clock, model, then sample on the next negedge.
  task automatic step(input logic d, input logic e, input logic s);
    din = d; en = e; sync = s;
    @(posedge clk);
    model_step(d, e, s);
    @(negedge clk);
    check_all();
    if (bus_s.frame_valid) fv_cnt++;
  endtask

  task automatic send_frame(input logic [15:0] w, input bit with_sync, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      step(w[i], 1'b1, with_sync && i == 0);
      if (gaps) step(1'($urandom), 1'b0, 1'($urandom));
    end
  endtask

  // Async reset in the middle of a low clock phase, checked before the next edge.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_dout",   bus_s.dout,              16'h0000);
    check("rst_locked", 16'(bus_s.locked),       16'd0);
    check("rst_slot",   16'(bus_s.slot),         16'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic d, e, s;
    logic fv, lk;
    logic [3:0]  sl;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[24];

  initial begin
    logic [15:0] w;
    rst = 1'b1; din = 1'b0; en = 1'b0; sync = 1'b0;
    model_reset();
    #1;
    check("por_dout", bus_s.dout, 16'h0000);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Idle bits without sync, one A5C3 frame, then en=0 edges with sync high.
    w = 16'hA5C3;
    for (int i = 0; i < 4; i++)
      tbl[i] = '{d:1'b1, e:1'b1, s:1'b0, fv:1'b0, lk:1'b0, sl:4'd0, dout:16'h0000};
    for (int i = 0; i < 16; i++)
      tbl[4+i] = '{d:w[i], e:1'b1, s:(i == 0), fv:(i == 15), lk:1'b1,
                   sl:4'((i + 1) % 16), dout:(i == 15) ? w : 16'h0000};
    for (int i = 20; i < 24; i++)
      tbl[i] = '{d:1'b1, e:1'b0, s:1'b1, fv:1'b0, lk:1'b1, sl:4'd0, dout:w};
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].d, tbl[i].e, tbl[i].s);
      check("tbl_fv",     16'(bus_s.frame_valid), 16'(tbl[i].fv));
      check("tbl_locked", 16'(bus_s.locked),      16'(tbl[i].lk));
      check("tbl_slot",   16'(bus_s.slot),        16'(tbl[i].sl));
      check("tbl_dout",   bus_s.dout,             tbl[i].dout);
    end

    // Two framed words with en gaps; exactly two pulses.
    fv_cnt = 0;
    send_frame(16'h1234, 1'b1, 1'b1);
    check("gap_dout1", bus_s.dout, 16'h1234);
    send_frame(16'hFFFF, 1'b1, 1'b1);
    check("gap_dout2", bus_s.dout, 16'hFFFF);
    check("gap_fv_count", 16'(fv_cnt), 16'd2);

    // Sync reasserted at slot 7.
    w = 16'h0F0F;
    for (int i = 0; i < 7; i++) step(w[i], 1'b1, i == 0);
    w = 16'h6D21;
    step(w[0], 1'b1, 1'b1);
    check("early_serr", 16'(bus_s.sync_err),    16'd1);
    check("early_slot", 16'(bus_s.slot),        16'd1);
    check("early_fv",   16'(bus_s.frame_valid), 16'd0);
    for (int i = 1; i < 16; i++) step(w[i], 1'b1, 1'b0);
    check("early_frame", bus_s.dout, 16'h6D21);

    // Missing sync at the next frame's slot 0.
    send_frame(16'h5A5A, 1'b1, 1'b0);
    w = 16'h3C96;
    step(w[0], 1'b1, 1'b0);
    check("miss_serr_s",   16'(bus_s.sync_err), 16'd1);
    check("miss_locked_s", 16'(bus_s.locked),   16'd0);
    check("miss_slot_s",   16'(bus_s.slot),     16'd0);
    check("miss_serr_f",   16'(bus_f.sync_err), 16'd0);
    for (int i = 1; i < 16; i++) step(w[i], 1'b1, 1'b0);
    check("miss_fv_f",   16'(bus_f.frame_valid), 16'd1);
    check("miss_dout_f", bus_f.dout,             16'h3C96);
    check("miss_dout_s", bus_s.dout,             16'h5A5A);

    // Async reset at slot 9, then unsynced bits must be ignored.
    w = 16'hBEEF;
    for (int i = 0; i < 9; i++) step(w[i], 1'b1, i == 0);
    check("pre_rst_slot", 16'(bus_s.slot), 16'd9);
    mid_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    check("post_rst_dout", bus_f.dout, 16'h0000);

    // Randomized traffic with syncs mostly on frame boundaries.
    for (int n = 0; n < 3000; n++) begin
      logic e, s;
      if ($urandom_range(0, 599) == 0) mid_reset();
      e = ($urandom_range(0, 3) != 0);
      s = (m_len[1] == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 59) == 0);
      step(1'($urandom), e, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
